// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/execute sequencer for a single-instruction datapath: owns the PC,
// fetches over valid/ready, and gates register-file writes. Optional: INSTR_SEQ_EBREAK_HALT_EN.
module instr_sequencer #(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0,
  parameter int               CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_addr,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  output logic [31:0]       instruction,
  output logic              rf_we,
  input  logic              br_taken,
  input  logic [XLEN-1:0]   br_target,
  output logic [XLEN-1:0]   pc,
  output logic [CNT_W-1:0]  retired,
  output logic              halted,
  output logic              illegal
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    WAIT_RSP = 3'd2,
    EXEC     = 3'd3,
    WB       = 3'd4,
    HALT     = 3'd5
  } state_t;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  state_t            state_reg, state_next;
  logic [XLEN-1:0]   pc_reg, pc_next;
  logic [31:0]       instr_reg, instr_next;
  logic [CNT_W-1:0]  retired_reg, retired_next;
  logic              halted_reg, halted_next;
  logic              illegal_reg, illegal_next;
  logic              writes_rd;
  logic              ebreak_halt;

  always_comb begin
    writes_rd = 1'b0;
    case (instr_reg[6:0])
      7'b0010011, 7'b0110011, 7'b0110111, 7'b0010111,
      7'b1101111, 7'b1100111, 7'b0000011: writes_rd = (instr_reg[11:7] != 5'd0);
      default:                            writes_rd = 1'b0;
    endcase
  end

`ifdef INSTR_SEQ_EBREAK_HALT_EN
  assign ebreak_halt = (instr_reg == EBREAK);
`else
  assign ebreak_halt = 1'b0;
`endif

  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    instr_next     = instr_reg;
    retired_next   = retired_reg;
    halted_next    = halted_reg;
    illegal_next   = illegal_reg;
    rf_we          = 1'b0;
    imem_req_valid = 1'b0;
    case (state_reg)
      IDLE: begin
        if (run) state_next = FETCH;
      end
      FETCH: begin
        imem_req_valid = 1'b1;
        if (imem_req_ready) state_next = WAIT_RSP;
      end
      WAIT_RSP: begin
        if (imem_rsp_valid) begin
          instr_next = imem_rsp_data;
          if (imem_rsp_data[1:0] != 2'b11) begin
            illegal_next = 1'b1;
            state_next   = HALT;
          end else begin
            state_next = EXEC;
          end
        end
      end
      EXEC: begin
        state_next = WB;
      end
      WB: begin
        // halted marks a deliberate EBREAK stop; an illegal-word stop is reported by illegal alone
        if (ebreak_halt) begin
          halted_next = 1'b1;
          state_next  = HALT;
        end else begin
          rf_we        = writes_rd;
          pc_next      = br_taken ? (br_target & {{(XLEN-2){1'b1}}, 2'b00})
                                  : pc_reg + XLEN'(4);
          retired_next = retired_reg + CNT_W'(1);
          state_next   = run ? FETCH : IDLE;
        end
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      pc_reg      <= RESET_PC;
      instr_reg   <= NOP;
      retired_reg <= '0;
      halted_reg  <= 1'b0;
      illegal_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      instr_reg   <= instr_next;
      retired_reg <= retired_next;
      halted_reg  <= halted_next;
      illegal_reg <= illegal_next;
    end
  end

  assign imem_addr   = pc_reg;
  assign pc          = pc_reg;
  assign instruction = instr_reg;
  assign retired     = retired_reg;
  assign halted      = halted_reg;
  assign illegal     = illegal_reg;

endmodule
